maxpool_stream_2x2: RTL and testbench
=====================================

Name: maxpool_stream_2x2

Overview:
- Streaming 2x2, stride-2 max-pooling stage placed directly downstream of the multi-filter convolution layer.
- Consumes conv feature-map pixels one per handshake, in flattened order: channel-major, then row-major, then column.
- Emits pooled pixels in the same order.
- Uses one line buffer of partial maxima, so a full feature map is never stored.

Parameters:
- DATA_WIDTH, 32: pixel width; signed two's complement.
- C, 16: channels (feature maps) per frame.
- IH, 10: input feature-map height (conv output H-F+1).
- IW, 10: input feature-map width (conv output W-F+1).
- Derived values: OH = IH/2 and OW = IW/2 (floor).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel.
- in_data  in  DATA_WIDTH  input pixel.
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts the pooled pixel.
- out_data  out  DATA_WIDTH  pooled pixel.
- out_last  out  1  marks the final pooled pixel of a frame (ch C-1, row OH-1, col OW-1).
- frame_done  out  1  one-cycle pulse when the out_last beat is accepted.

Behaviour:
- Reset (asynchronous, active-high) clears state and outputs:
  - col, row and ch counters go to 0.
  - pair register is cleared; line buffer contents are don't-care.
  - out_valid=0, out_data=0, out_last=0, frame_done=0.
  - Reset mid-frame discards all partial results; the next accepted pixel is (ch0, r0, c0).
- Input accept rule: accept = in_valid && in_ready, where in_ready = !out_valid || out_ready.
  - The input stalls while an unaccepted output is held, even for beats that would not produce output.
  - in_ready is combinational from out_valid/out_ready only, never from in_valid.
- Counters advance on each accept:
  - col wraps at IW-1, then row increments.
  - row wraps at IH-1, then ch increments.
  - ch wraps at C-1 to 0; frames are back-to-back with no gap.
- Per accepted pixel p at (row r, col c), valid region only (c < 2*OW and r < 2*OH):
  - c even: pair <= p.
  - c odd: m = max(pair, p), compared signed.
  - r even and c odd: linebuf[c/2] <= m.
  - r odd and c odd: result = max(linebuf[c/2], m), registered into out_data with out_valid=1 next cycle.
- Trailing odd column (c = IW-1 with IW odd) and trailing odd row (r = IH-1 with IH odd) are accepted, counted and discarded.
- Latency: out_valid rises on the clock edge that accepts the 4th pixel of a window, so out_data is visible the cycle after that acceptance.
- Output register: out_valid clears on out_ready unless a new result is loaded on the same edge.
  - Back-to-back load and drain is allowed: a full-rate stream sustains one input per cycle when out_ready=1.
  - out_data, out_valid and out_last are held stable while out_valid && !out_ready.
- out_last=1 together with the result for (ch C-1, last pooled window).
- frame_done pulses for exactly one cycle after the out_last beat is accepted.
- Line buffer: OW entries of DATA_WIDTH, indexed by c/2; it is reused across rows and channels without clearing.
- No arithmetic widening; max is a pure signed comparison and select.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: result = (max < 0) ? 0 : max. ReLU is fused at the output register, with no extra latency. Equivalent to ReLU-before-pool.
- Undefined: the raw signed max is output and negative values pass through.

Test Plan:
- Single 2x2 window (C=1, IH=IW=2), inputs 3, -7, 12, 5 with out_ready=1 -> one beat, out_data=12, out_last=1, frame_done pulses once; first out_valid on the edge accepting the 4th pixel.
- Default params, ramp in_data=index 0..1599, continuous valid/ready -> 400 outputs, each equal to the window bottom-right index (ch0 first = 11); out_last only on the 400th beat; in_ready never drops.
- All-negative window -8, -3, -5, -9 -> out_data=-3 without POOL_RELU_EN; 0 with it.
- Backpressure: hold out_ready=0 for 5 cycles after the first output -> in_ready=0 and out_data stable throughout; no pixel is lost; results match the no-stall run.
- Odd size IH=IW=5, C=1, ramp 0..24 -> 4 outputs: 6, 8, 16, 18; row 4 and col 4 are consumed and dropped; next frame restarts cleanly.
- Assert reset after 7 pixels of a frame, then stream a full frame -> outputs match a fresh frame; no stale out_valid.

Source files
------------

// File: rtl/maxpool_stream_2x2.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_stream_2x2
// Brief    : Streaming 2x2 / stride-2 signed max-pooling stage. Pixels arrive
//            channel-major, row-major, column-minor; pooled pixels leave in the
//            same order. A single line buffer of partial (row-pair) maxima is
//            kept, so the feature map itself is never stored.
// Options  : define POOL_RELU_EN to clamp negative pooled results to zero at
//            the output register (same as ReLU applied before pooling).
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_stream_2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int C          = 16,
  parameter int IH         = 10,
  parameter int IW         = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_done
);

  localparam int c_oh    = IH / 2;
  localparam int c_ow    = IW / 2;
  localparam int c_col_w = (IW > 1) ? $clog2(IW) : 1;
  localparam int c_row_w = (IH > 1) ? $clog2(IH) : 1;
  localparam int c_ch_w  = (C > 1) ? $clog2(C) : 1;
  localparam int c_idx_w = (c_ow > 1) ? $clog2(c_ow) : 1;

  localparam logic [c_col_w-1:0] c_col_last     = c_col_w'(IW - 1);
  localparam logic [c_row_w-1:0] c_row_last     = c_row_w'(IH - 1);
  localparam logic [c_ch_w-1:0]  c_ch_last      = c_ch_w'(C - 1);
  localparam logic [c_col_w-1:0] c_col_win_last = c_col_w'(2 * c_ow - 1);
  localparam logic [c_row_w-1:0] c_row_win_last = c_row_w'(2 * c_oh - 1);

  logic [c_col_w-1:0]           r_col;
  logic [c_row_w-1:0]           r_row;
  logic [c_ch_w-1:0]            r_ch;
  logic signed [DATA_WIDTH-1:0] r_pair;
  logic signed [DATA_WIDTH-1:0] r_linebuf [0:c_ow-1];

  logic                         w_accept;
  logic                         w_col_ok;
  logic                         w_row_ok;
  logic                         w_in_win;
  logic                         w_emit;
  logic                         w_emit_last;
  logic [c_idx_w-1:0]           w_idx;
  logic signed [DATA_WIDTH-1:0] w_pix;
  logic signed [DATA_WIDTH-1:0] w_lb;
  logic signed [DATA_WIDTH-1:0] w_pair_max;
  logic signed [DATA_WIDTH-1:0] w_win_max;
  logic signed [DATA_WIDTH-1:0] w_result;

  // Input may only advance when the output register is free or being drained.
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // A trailing odd column / row is counted but never joins a window.
  assign w_col_ok = ((IW % 2) == 0) || (r_col != c_col_last);
  assign w_row_ok = ((IH % 2) == 0) || (r_row != c_row_last);
  assign w_in_win = w_col_ok && w_row_ok;

  assign w_idx = c_idx_w'(r_col >> 1);
  assign w_pix = $signed(in_data);
  assign w_lb  = r_linebuf[w_idx];

  // Horizontal max of the current column pair, then vertical max with the
  // pair kept from the even row above.
  assign w_pair_max = (r_pair > w_pix) ? r_pair : w_pix;
  assign w_win_max  = (w_lb > w_pair_max) ? w_lb : w_pair_max;

`ifdef POOL_RELU_EN
  assign w_result = w_win_max[DATA_WIDTH-1] ? '0 : w_win_max;
`else
  assign w_result = w_win_max;
`endif

  // The 4th pixel of a window is the odd-row, odd-column one.
  assign w_emit      = w_accept && w_in_win && r_col[0] && r_row[0];
  assign w_emit_last = (r_ch == c_ch_last) && (r_row == c_row_win_last) &&
                       (r_col == c_col_win_last);

  // Position counters: column, then row, then channel; frames run back-to-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
      r_ch  <= '0;
    end else if (w_accept) begin
      if (r_col == c_col_last) begin
        r_col <= '0;
        if (r_row == c_row_last) begin
          r_row <= '0;
          r_ch  <= (r_ch == c_ch_last) ? '0 : r_ch + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Hold the even-column pixel until its odd-column partner arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pair <= '0;
    end else if (w_accept && w_in_win && !r_col[0]) begin
      r_pair <= w_pix;
    end
  end

  // Even rows park their column-pair maxima for the odd row below.
  always_ff @(posedge clk) begin
    if (w_accept && w_in_win && r_col[0] && !r_row[0]) begin
      r_linebuf[w_idx] <= w_pair_max;
    end
  end

  // Output register: load a finished window, else release once taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (w_emit) begin
      out_valid <= 1'b1;
      out_data  <= w_result;
      out_last  <= w_emit_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // One-cycle pulse after the final pooled pixel of a frame is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_stream_2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_stream_2x2
// Brief    : Scoreboard bench for maxpool_stream_2x2. Three instances:
//            k=0 default 16x10x10, k=1 1x5x5 (odd size), k=2 1x2x2 (single
//            window). Expected pooled pixels come from whole-frame arrays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_stream_2x2;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid   [3];
  logic [DW-1:0] in_data    [3];
  logic          out_ready  [3];
  logic          in_ready   [3];
  logic [DW-1:0] out_data   [3];
  logic          out_valid  [3];
  logic          out_last   [3];
  logic          frame_done [3];

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      maxpool_stream_2x2 #(
        .DATA_WIDTH(DW),
        .C         ((k == 0) ? 16 : 1),
        .IH        ((k == 0) ? 10 : ((k == 1) ? 5 : 2)),
        .IW        ((k == 0) ? 10 : ((k == 1) ? 5 : 2))
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[k]),
        .in_ready  (in_ready[k]),
        .in_data   (in_data[k]),
        .out_valid (out_valid[k]),
        .out_ready (out_ready[k]),
        .out_data  (out_data[k]),
        .out_last  (out_last[k]),
        .frame_done(frame_done[k])
      );
    end
  endgenerate

  function automatic int cfg_c(input int k);
    return (k == 0) ? 16 : 1;
  endfunction

  function automatic int cfg_h(input int k);
    return (k == 0) ? 10 : ((k == 1) ? 5 : 2);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  typedef struct packed {
    logic [1:0]    k;
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  exp_t q[$];
  int   fr[];
  int   total = 0;
  int   bad = 0;
  int   stalls = 0;
  int   bp_mode = 0;

  bit   pend = 0;
  int   pend_k = 0;
  bit   pend_win = 0;
  logic pend_ordy = 1'b0;
  logic pend_ov = 1'b0;

  logic          prev_hold [3];
  logic [DW-1:0] prev_data [3];
  logic          prev_last [3];
  logic          prev_fd   [3];

  task automatic chk(input string name, input logic signed [DW-1:0] act,
                     input logic signed [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // out_valid one cycle after each accept: set by a window's 4th pixel,
  // cleared if the held beat was taken, otherwise unchanged.
  task automatic check_pending();
    if (pend) begin
      pend = 0;
      if (pend_win)       chk("latency_valid", out_valid[pend_k], 1);
      else if (pend_ordy) chk("valid_clear", out_valid[pend_k], 0);
      else                chk("valid_hold", out_valid[pend_k], pend_ov);
    end
  endtask

  task automatic send(input int k, input int d, input bit win);
    bit   got = 0;
    logic rdy, ordy, ov;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    for (int t = 0; t < 500 && !got; t++) begin
      @(negedge clk);
      check_pending();
      rdy  = in_ready[k];
      ordy = out_ready[k];
      ov   = out_valid[k];
      @(posedge clk);
      if (rdy) got = 1;
      else     stalls++;
    end
    #1;
    in_valid[k] = 1'b0;
    if (!got) chk("accept_timeout", got, 1);
    else begin
      pend = 1; pend_k = k; pend_win = win; pend_ordy = ordy; pend_ov = ov;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 5000 && (q.size() != 0 || pend); t++) begin
      @(negedge clk);
      check_pending();
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    sync();
  endtask

  // mode 0: ramp, 1: random, 2: frame already loaded into fr
  task automatic run_frame(input int k, input int mode);
    int   c, h, n, oh, base, m, r, cc;
    exp_t e;
    c = cfg_c(k); h = cfg_h(k); n = c * h * h; oh = h / 2;
    if (mode != 2) begin
      fr = new[n];
      foreach (fr[i])
        fr[i] = (mode == 0) ? i :
                (($urandom % 2) != 0) ? int'($urandom) : int'($urandom_range(20)) - 10;
    end
    for (int ch = 0; ch < c; ch++)
      for (int i = 0; i < oh; i++)
        for (int j = 0; j < oh; j++) begin
          base = ch * h * h + (2 * i) * h + 2 * j;
          m = imax(imax(fr[base], fr[base + 1]), imax(fr[base + h], fr[base + h + 1]));
`ifdef POOL_RELU_EN
          if (m < 0) m = 0;
`endif
          e.k = 2'(k);
          e.d = m;
          e.last = (ch == c - 1) && (i == oh - 1) && (j == oh - 1);
          q.push_back(e);
        end
    for (int idx = 0; idx < n; idx++) begin
      r  = (idx / h) % h;
      cc = idx % h;
      send(k, fr[idx], (r % 2 == 1) && (cc % 2 == 1) && (r < 2 * oh) && (cc < 2 * oh));
    end
    drain();
  endtask

  // Per-cycle monitor: handshake rule, hold stability, frame_done, scoreboard.
  task automatic mon();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        prev_hold[k] = 1'b0;
        prev_fd[k]   = 1'b0;
      end else begin
        chk("in_ready_rule", in_ready[k], !out_valid[k] || out_ready[k]);
        if (prev_hold[k]) begin
          chk("hold_valid", out_valid[k], 1);
          chk("hold_data", out_data[k], prev_data[k]);
          chk("hold_last", out_last[k], prev_last[k]);
        end
        chk("frame_done", frame_done[k], prev_fd[k]);
        if (out_valid[k] && out_ready[k]) begin
          chk("output_expected", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_inst", k, e.k);
            chk("out_data", out_data[k], e.d);
            chk("out_last", out_last[k], e.last);
          end
        end
        prev_hold[k] = out_valid[k] && !out_ready[k];
        prev_data[k] = out_data[k];
        prev_last[k] = out_last[k];
        prev_fd[k]   = out_valid[k] && out_ready[k] && out_last[k];
      end
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b1;
      prev_hold[k] = 1'b0; prev_data[k] = '0; prev_last[k] = 1'b0; prev_fd[k] = 1'b0;
    end
    fork
      forever begin
        @(negedge clk);
        mon();
      end
      forever begin
        @(posedge clk);
        #1;
        if (bp_mode == 1)
          for (int k = 0; k < 3; k++) out_ready[k] = (($urandom % 3) != 0);
      end
    join_none

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", out_valid[k], 0);
      chk("rst_out_data", out_data[k], 0);
      chk("rst_out_last", out_last[k], 0);
      chk("rst_frame_done", frame_done[k], 0);
    end
    sync();
    reset = 1'b0;
    sync();

    // single window, mixed signs
    fr = new[4];
    fr[0] = 3; fr[1] = -7; fr[2] = 12; fr[3] = 5;
    run_frame(2, 2);

    // all-negative window
    fr = new[4];
    fr[0] = -8; fr[1] = -3; fr[2] = -5; fr[3] = -9;
    run_frame(2, 2);

    // full-size ramp at full rate: input must never stall
    stalls = 0;
    run_frame(0, 0);
    chk("ramp_no_stall", stalls, 0);

    // odd 5x5 frame: trailing row/column dropped; next frame restarts cleanly
    run_frame(1, 0);
    run_frame(1, 1);

    // random data with random downstream backpressure
    bp_mode = 1;
    run_frame(0, 1);
    run_frame(2, 1);
    run_frame(1, 1);
    bp_mode = 0;
    for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
    sync();

    // out_ready held low for 5 cycles after the first output
    bp_mode = 2;
    fork
      run_frame(0, 1);
      begin
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(posedge clk);
          #2;
          seen = out_valid[0];
        end
        chk("bp_first_output", seen, 1);
        if (seen) begin
          out_ready[0] = 1'b0;
          repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready[0], 0);
          end
          @(posedge clk);
          #2;
          out_ready[0] = 1'b1;
        end
      end
    join
    bp_mode = 0;

    // reset mid-frame after 7 pixels, then a fresh full frame
    for (int i = 0; i < 7; i++) send(0, int'($urandom), 0);
    @(negedge clk);
    check_pending();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_out_data", out_data[0], 0);
    chk("midrst_out_last", out_last[0], 0);
    chk("midrst_frame_done", frame_done[0], 0);
    chk("midrst_queue", q.size(), 0);
    sync();
    reset = 1'b0;
    sync();
    run_frame(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
